// File: rtl/vga_pixel_fifo_ctrl_pkg.sv
// Shared definitions for the VGA pixel FIFO pacing controller.
//   state_t      : pacing FSM states (FILL = waiting for prefill, RUN = strobing pal_dac)
//   OFS_*        : bit offsets of the control fields of a FIFO entry, counted above the pixel word
//   cnt_width()  : width of the cadence counter for a given divide ratio (never zero)
package vga_pixel_fifo_ctrl_pkg;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Entry layout: {hs, vs, von_h, von_v, char[PIX_W-1:0]}
    localparam int unsigned CTRL_W    = 4;
    localparam int unsigned OFS_VON_V = 0;
    localparam int unsigned OFS_VON_H = 1;
    localparam int unsigned OFS_VS    = 2;
    localparam int unsigned OFS_HS    = 3;

    function automatic int unsigned cnt_width(input int unsigned div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/vga_pixel_fifo_ctrl_fifo.sv
// Generic single-clock FIFO used as the elastic pixel buffer.
//   clk, rst        : clock, asynchronous active-high reset (empties the FIFO)
//   i_push, i_data  : write request and entry; accepted when not full, or when full
//                     and a pop is accepted in the same cycle
//   i_pop           : read request; ignored when empty
//   o_data          : head entry (valid when !o_empty)
//   o_full, o_empty : occupancy flags
//   o_level         : occupancy 0..DEPTH
module vga_pixel_fifo_ctrl_fifo #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Pointers carry one extra bit so full and empty are distinguishable.
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      w_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_level   = r_wr_ptr - r_rd_ptr;
    assign o_level   = w_level;
    assign o_full    = (w_level == (AW+1)'(DEPTH));
    assign o_empty   = (w_level == '0);
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: contents are only read behind the pointers.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/vga_pixel_fifo_ctrl.sv
// Elastic pixel buffer and pacing controller between vga_sequencer and vga_pal_dac.
// Gates crtc/sequencer advance on memory ack and FIFO level, buffers sequencer output and
// strobes pal_dac at a fixed cadence of DIV clocks once START_LVL entries are buffered.
//   clk, rst                       : pixel clock, asynchronous active-high reset
//   csr_stb_i, csr_ack_i           : sequencer memory strobe / ack
//   enable_fetch_o                 : advance enable to crtc and sequencer
//   seq_we_i, seq_hs_i, seq_vs_i,
//   seq_von_h_i, seq_von_v_i,
//   seq_char_i                     : sequencer output and its valid
//   enable_pal_dac_o               : one-cycle strobe, outputs below are valid with it
//   hs_o, vs_o, von_h_o, von_v_o,
//   char_o                         : registered outputs to pal_dac
//   level_o                        : FIFO occupancy
//   clr_err_i                      : clears the sticky error flags
//   underflow_o, overflow_o        : sticky strobe-while-empty / write-while-full flags
//
// Parameters: DEPTH power of 2 >= 4, DIV >= 1, AF_MARGIN < DEPTH, START_LVL in 1..DEPTH.
module vga_pixel_fifo_ctrl
    import vga_pixel_fifo_ctrl_pkg::*;
#(
    parameter int unsigned PIX_W     = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned DIV       = 4,
    parameter int unsigned AF_MARGIN = 3,
    parameter int unsigned START_LVL = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     csr_stb_i,
    input  logic                     csr_ack_i,
    output logic                     enable_fetch_o,
    input  logic                     seq_we_i,
    input  logic                     seq_hs_i,
    input  logic                     seq_vs_i,
    input  logic                     seq_von_h_i,
    input  logic                     seq_von_v_i,
    input  logic [PIX_W-1:0]         seq_char_i,
    output logic                     enable_pal_dac_o,
    output logic                     hs_o,
    output logic                     vs_o,
    output logic                     von_h_o,
    output logic                     von_v_o,
    output logic [PIX_W-1:0]         char_o,
    output logic [$clog2(DEPTH):0]   level_o,
    input  logic                     clr_err_i,
    output logic                     underflow_o,
    output logic                     overflow_o
);

    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
    localparam int unsigned ENT_W = PIX_W + CTRL_W;
    localparam int unsigned CNT_W = cnt_width(DIV);

    localparam logic [LVL_W-1:0] START_LEVEL = LVL_W'(START_LVL);
    localparam logic [LVL_W-1:0] FETCH_LIMIT = LVL_W'(DEPTH - AF_MARGIN);
    localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(DIV - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_decide;
    logic               w_cnt_run;
    logic               w_pop;
    logic               w_starve;
    logic               w_overflow_evt;

    logic [ENT_W-1:0]   w_entry_in;
    logic [ENT_W-1:0]   w_head;
    logic               w_full;
    logic               w_empty;
    logic [LVL_W-1:0]   w_level;

    logic               r_strobe;
    logic               r_hs;
    logic               r_vs;
    logic               r_von_h;
    logic               r_von_v;
    logic [PIX_W-1:0]   r_char;
    logic               r_underflow;
    logic               r_overflow;

    // ------------------------------------------------------------------
    // Pixel buffer
    // ------------------------------------------------------------------
    assign w_entry_in = {seq_hs_i, seq_vs_i, seq_von_h_i, seq_von_v_i, seq_char_i};

    vga_pixel_fifo_ctrl_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (seq_we_i),
        .i_data  (w_entry_in),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    // A write while full is only lost if no pop frees a slot in the same cycle.
    assign w_overflow_evt = seq_we_i & w_full & ~w_pop;

    // ------------------------------------------------------------------
    // Fetch gating: an outstanding strobe stalls until acked; an acked
    // cycle always completes, AF_MARGIN keeps room for it.
    // ------------------------------------------------------------------
    assign enable_fetch_o = ~rst & ((csr_stb_i & csr_ack_i) |
                                    (~csr_stb_i & (w_level < FETCH_LIMIT)));

    // ------------------------------------------------------------------
    // Pacing FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_FILL;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FILL: if (w_level >= START_LEVEL) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_starve)               w_state_nxt = ST_FILL;
            default:                             w_state_nxt = ST_FILL;
        endcase
    end

    always_comb begin
        w_cnt_run = 1'b0;
        w_decide  = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_cnt_run = 1'b1;
                w_decide  = (r_cnt == CNT_MAX);
            end
            default: ;
        endcase
    end

    assign w_pop    = w_decide & ~w_empty;
    assign w_starve = w_decide &  w_empty;

    // Cadence counter, parked at 0 while filling so RUN always starts a full period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  r_cnt <= '0;
        else if (!w_cnt_run)      r_cnt <= '0;
        else if (r_cnt == CNT_MAX) r_cnt <= '0;
        else                      r_cnt <= r_cnt + 1'b1;
    end

    // ------------------------------------------------------------------
    // Output registers: loaded on the decision cycle so data and strobe
    // appear together one clock later. A starved strobe blanks video but
    // holds the syncs so pal_dac timing stays coherent.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_strobe <= 1'b0;
            r_hs     <= 1'b0;
            r_vs     <= 1'b0;
            r_von_h  <= 1'b0;
            r_von_v  <= 1'b0;
            r_char   <= '0;
        end else begin
            r_strobe <= w_decide;
            if (w_pop) begin
                r_hs    <= w_head[PIX_W + OFS_HS];
                r_vs    <= w_head[PIX_W + OFS_VS];
                r_von_h <= w_head[PIX_W + OFS_VON_H];
                r_von_v <= w_head[PIX_W + OFS_VON_V];
                r_char  <= w_head[PIX_W-1:0];
            end else if (w_starve) begin
                r_von_h <= 1'b0;
                r_von_v <= 1'b0;
            end
        end
    end

    // Sticky flags: a same-cycle event beats the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_underflow <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_underflow <= (r_underflow & ~clr_err_i) | w_starve;
            r_overflow  <= (r_overflow  & ~clr_err_i) | w_overflow_evt;
        end
    end

    assign enable_pal_dac_o = r_strobe;
    assign hs_o             = r_hs;
    assign vs_o             = r_vs;
    assign von_h_o          = r_von_h;
    assign von_v_o          = r_von_v;
    assign char_o           = r_char;
    assign level_o          = w_level;
    assign underflow_o      = r_underflow;
    assign overflow_o       = r_overflow;

endmodule

// File: tb/tb_vga_pixel_fifo_ctrl.sv
module tb_vga_pixel_fifo_ctrl;

    localparam int PIX_W = 8;
    localparam int DEPTH = 16;
    localparam int DIV   = 4;
    localparam int AF    = 3;
    localparam int START = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic stb = 0, ack = 0, we = 0, hs = 0, vs = 0, vh = 0, vv = 0, clr = 0;
    logic [7:0] ch = 0;

    logic       fetch0, strobe0, hs0, vs0, vh0, vv0, uf0, of0;
    logic [7:0] ch0;
    logic [4:0] lvl0;
    logic       fetch1, strobe1, hs1, vs1, vh1, vv1, uf1, of1;
    logic [7:0] ch1;
    logic [4:0] lvl1;

    vga_pixel_fifo_ctrl dut0 (
        .clk(clk), .rst(rst), .csr_stb_i(stb), .csr_ack_i(ack), .enable_fetch_o(fetch0),
        .seq_we_i(we), .seq_hs_i(hs), .seq_vs_i(vs), .seq_von_h_i(vh), .seq_von_v_i(vv),
        .seq_char_i(ch), .enable_pal_dac_o(strobe0), .hs_o(hs0), .vs_o(vs0),
        .von_h_o(vh0), .von_v_o(vv0), .char_o(ch0), .level_o(lvl0), .clr_err_i(clr),
        .underflow_o(uf0), .overflow_o(of0));

    vga_pixel_fifo_ctrl #(.DIV(1)) dut1 (
        .clk(clk), .rst(rst), .csr_stb_i(stb), .csr_ack_i(ack), .enable_fetch_o(fetch1),
        .seq_we_i(we), .seq_hs_i(hs), .seq_vs_i(vs), .seq_von_h_i(vh), .seq_von_v_i(vv),
        .seq_char_i(ch), .enable_pal_dac_o(strobe1), .hs_o(hs1), .vs_o(vs1),
        .von_h_o(vh1), .von_v_o(vv1), .char_o(ch1), .level_o(lvl1), .clr_err_i(clr),
        .underflow_o(uf1), .overflow_o(of1));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model for dut0: a queue of entries plus the edge number
    // of the next scheduled strobe (-1 while prefilling). Once START
    // entries are seen, strobes are scheduled every DIV edges starting
    // DIV edges after the edge that notices the prefill.
    // ------------------------------------------------------------------
    logic [11:0] mq[$];
    int   m_n   = 0;
    int   m_nxt = -1;
    logic m_stb = 0, m_hs = 0, m_vs = 0, m_vh = 0, m_vv = 0, m_uf = 0, m_of = 0;
    logic [7:0] m_ch = 0;

    always @(posedge clk or posedge rst) begin : model
        logic uf_e, of_e;
        logic [11:0] e;
        if (rst) begin
            mq.delete();
            m_n = 0; m_nxt = -1;
            m_stb = 0; m_hs = 0; m_vs = 0; m_vh = 0; m_vv = 0; m_ch = 0; m_uf = 0; m_of = 0;
        end else begin
            m_n++;
            uf_e = 0; of_e = 0; m_stb = 0;
            if (m_nxt == m_n) begin
                m_stb = 1;
                if (mq.size() == 0) begin
                    m_vh = 0; m_vv = 0; uf_e = 1; m_nxt = -1;
                end else begin
                    e = mq.pop_front();
                    {m_hs, m_vs, m_vh, m_vv, m_ch} = e;
                    m_nxt = m_n + DIV;
                end
            end else if (m_nxt < 0 && mq.size() >= START) begin
                m_nxt = m_n + DIV;
            end
            if (we) begin
                if (mq.size() < DEPTH) mq.push_back({hs, vs, vh, vv, ch});
                else                   of_e = 1;
            end
            m_uf = (m_uf & !clr) | uf_e;
            m_of = (m_of & !clr) | of_e;
        end
    end

    task automatic check_all();
        int expf;
        expf = (!rst && ((stb && ack) || (!stb && mq.size() < DEPTH - AF))) ? 1 : 0;
        chk("fetch",  fetch0,  expf);
        chk("level",  lvl0,    mq.size());
        chk("strobe", strobe0, m_stb);
        chk("hs",     hs0,     m_hs);
        chk("vs",     vs0,     m_vs);
        chk("von_h",  vh0,     m_vh);
        chk("von_v",  vv0,     m_vv);
        chk("char",   ch0,     m_ch);
        chk("uflow",  uf0,     m_uf);
        chk("oflow",  of0,     m_of);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        we = 0; stb = 0; ack = 0; clr = 0;
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    typedef struct {
        int n_push;
        logic stb, ack;
        int exp_fetch, exp_lvl, exp_of;
    } vec_t;

    vec_t vecs[8];
    int   cnt, k, first, last, exp_ch, ref_lvl, lvl8_at, prv;
    bit   seen;

    initial begin
        // Back-to-back pushes from reset: pops land at edges 13, 17, ...,
        // so the level runs 1..12, holds 12, then 13 .. 16 and stays full.
        vecs[0] = '{0,  1'b0, 1'b0, 1, 0,  0};
        vecs[1] = '{0,  1'b1, 1'b0, 0, 0,  0};
        vecs[2] = '{5,  1'b1, 1'b1, 1, 5,  0};
        vecs[3] = '{12, 1'b0, 1'b0, 1, 12, 0};
        vecs[4] = '{14, 1'b0, 1'b1, 0, 13, 0};
        vecs[5] = '{14, 1'b1, 1'b1, 1, 13, 0};
        vecs[6] = '{18, 1'b1, 1'b0, 0, 16, 0};
        vecs[7] = '{19, 1'b0, 1'b0, 0, 16, 1};

        // Reset values while reset is held
        rst = 1;
        tick();
        chk("rst_level", lvl0, 0);
        chk("rst_fetch", fetch0, 0);
        chk("rst_strobe", strobe0, 0);
        chk("rst_flags", {uf0, of0}, 0);
        do_reset();

        // Table: level reached by N pushes, then fetch gating for stb/ack
        foreach (vecs[i]) begin
            do_reset();
            for (int j = 0; j < vecs[i].n_push; j++) begin
                we = 1; ch = 8'(j); vh = 1; vv = 1;
                tick();
            end
            we = 0; stb = vecs[i].stb; ack = vecs[i].ack;
            #1;
            chk($sformatf("vec%0d_fetch", i), fetch0, vecs[i].exp_fetch);
            chk($sformatf("vec%0d_level", i), lvl0, vecs[i].exp_lvl);
            chk($sformatf("vec%0d_oflow", i), of0, vecs[i].exp_of);
            stb = 0; ack = 0;
            tick();
        end

        // Reset mid-stream with 10 entries
        do_reset();
        for (int j = 0; j < 10; j++) begin we = 1; ch = 8'(j); tick(); end
        chk("mid_pre_level", lvl0, 10);
        we = 0; rst = 1;
        #1;
        chk("mid_level", lvl0, 0);
        chk("mid_outs", {strobe0, hs0, vs0, vh0, vv0, ch0, uf0, of0}, 0);
        tick();
        rst = 0;
        cnt = 0;
        for (int j = 0; j < 7; j++) begin we = 1; tick(); cnt += strobe0; end
        we = 0;
        for (int j = 0; j < 20; j++) begin tick(); cnt += strobe0; end
        chk("mid_no_strobe", cnt, 0);
        we = 1; tick(); we = 0;
        for (int j = 0; j < 12; j++) begin tick(); cnt += strobe0; end
        chk("mid_strobe_after_8", (cnt > 0) ? 1 : 0, 1);

        // Cadence: push every DIV clocks, character stream must come out in order
        do_reset();
        k = 0; exp_ch = 0; first = 1; last = 0; lvl8_at = -1;
        for (int c = 0; c < 120; c++) begin
            if (c % DIV == 0) begin we = 1; ch = 8'(k); vh = 1; vv = 1; k++; end
            else we = 0;
            tick();
            if (lvl0 == START && lvl8_at < 0) lvl8_at = c;
            if (strobe0) begin
                // one edge to leave FILL, then a full DIV period, then the registered strobe
                if (first) chk("first_strobe_lat", c - lvl8_at, DIV + 1);
                else       chk("strobe_period", c - last, DIV);
                chk("cad_char", ch0, exp_ch & 255);
                chk("cad_von", {vh0, vv0}, 3);
                exp_ch++; first = 0; last = c;
            end
        end
        chk("cad_count", (exp_ch >= 20) ? 1 : 0, 1);
        chk("cad_no_uflow", uf0, 0);

        // Starve in RUN
        we = 0; seen = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            tick();
            if (uf0) begin
                seen = 1;
                chk("starve_strobe", strobe0, 1);
                chk("starve_blank", {vh0, vv0}, 0);
            end
        end
        chk("starve_seen", seen, 1);
        cnt = 0;
        for (int j = 0; j < 20; j++) begin tick(); cnt += strobe0; end
        chk("starve_no_strobe", cnt, 0);
        clr = 1; tick(); clr = 0;
        chk("starve_clr", uf0, 0);

        // Outstanding strobe held 5 clocks before ack
        do_reset();
        stb = 1; ack = 0;
        for (int j = 0; j < 5; j++) begin tick(); chk("stall_fetch", fetch0, 0); end
        ack = 1; we = 1; ch = 8'h55;
        #1;
        chk("ack_fetch", fetch0, 1);
        tick();
        stb = 0; ack = 0; we = 0;
        chk("ack_push_kept", lvl0, 1);

        // Almost-full drop of fetch, overflow, clear
        do_reset();
        seen = 0;
        for (int j = 0; j < 18; j++) begin
            we = 1; tick();
            if (!fetch0 && !seen) begin seen = 1; chk("af_level", lvl0, DEPTH - AF); end
        end
        chk("af_seen", seen, 1);
        chk("full_level", lvl0, DEPTH);
        tick();
        chk("ovf_flag", of0, 1);
        chk("ovf_level", lvl0, DEPTH);
        we = 0; clr = 1; tick(); clr = 0;
        chk("ovf_clr", of0, 0);

        // DIV=1 full rate on dut1
        do_reset();
        k = 0; prv = 0; ref_lvl = 0;
        for (int c = 0; c < 60; c++) begin
            we = 1; ch = 8'(k); vh = 1; vv = 1; k++;
            tick();
            if (c == 20) begin ref_lvl = lvl1; prv = ch1; end
            if (c > 20) begin
                chk("div1_level", lvl1, ref_lvl);
                chk("div1_strobe", strobe1, 1);
                chk("div1_char", ch1, (prv + 1) & 255);
                chk("div1_flags", {uf1, of1}, 0);
                prv = ch1;
            end
        end
        chk("div1_ref_level", (ref_lvl >= START) ? 1 : 0, 1);
        we = 0;

        // Randomized traffic at several write rates, checked against the model
        do_reset();
        foreach (vecs[s]) begin
            for (int c = 0; c < 400; c++) begin
                we  = ($urandom_range(99) < 15 + s * 10);
                ch  = 8'($urandom);
                {hs, vs, vh, vv} = 4'($urandom);
                stb = ($urandom_range(2) == 0);
                ack = $urandom_range(1);
                clr = ($urandom_range(31) == 0);
                tick();
            end
        end
        we = 0; stb = 0; ack = 0; clr = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
